// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared state encoding and default parameters for pc_seq
package pc_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_EXEC   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h8000_0000;
  localparam int          PC_STEP_DEF      = 4;

endpackage

// File: rtl/pc_seq_if.sv
// rtl/pc_seq_if.sv - instruction-memory fetch handshake between pc_seq and imem
interface pc_seq_if #(
  parameter int XLEN = 32
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/pc_seq_phase_cnt.sv
// rtl/pc_seq_phase_cnt.sv - execute-phase cycle counter, flags the last EXEC cycle
module phase_cnt #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic last_o
);

  logic [1:0] cnt_q, cnt_d;

  assign last_o = en_i && (cnt_q == 2'(EXEC_CYCLES - 1));

  // Returns to zero whenever the phase is not running, so every entry starts clean.
  always_comb begin
    cnt_d = '0;
    if (en_i && !last_o) cnt_d = cnt_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - fetch/exec/update PC sequencer; INSTRET_CNT_EN adds the instret counter
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter int              EXEC_CYCLES  = 1,
  parameter int              PC_STEP      = PC_STEP_DEF
) (
  input  logic            clk,
  input  logic            rst,
  pc_seq_if.master        imem,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next_seq,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  input  logic            halt_req,
  output logic            rf_wen_stb,
  output logic            pc_upd_stb,
  output logic            busy,
  output logic            misalign_err
`ifdef INSTRET_CNT_EN
  ,
  output logic [63:0]     instret
`endif
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic            err_q, err_d;
  logic            halt_pend_q, halt_pend_d;
  logic            exec_last;
  logic            misalign;
  logic            inst_load;

  phase_cnt #(.EXEC_CYCLES(EXEC_CYCLES)) u_phase_cnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q == ST_EXEC),
    .last_o (exec_last)
  );

  assign pc_next_seq = pc_q + XLEN'(PC_STEP);
  assign misalign    = (state_q == ST_UPDATE) && redirect && (target[1:0] != 2'b00);
  assign inst_load   = ((state_q == ST_FETCH) && imem.imem_gnt && imem.imem_rvalid) ||
                       ((state_q == ST_WAIT) && imem.imem_rvalid);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH:  if (imem.imem_gnt) state_d = imem.imem_rvalid ? ST_EXEC : ST_WAIT;
      ST_WAIT:   if (imem.imem_rvalid) state_d = ST_EXEC;
      ST_EXEC:   if (exec_last) state_d = ST_UPDATE;
      ST_UPDATE: state_d = (halt_req || halt_pend_q || misalign) ? ST_HALT : ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Strobes are masked while rst is high so a reset mid-instruction leaves nothing stale.
  always_comb begin
    imem.imem_req  = (state_q == ST_FETCH);
    imem.imem_addr = pc_q;
    rf_wen_stb     = !rst && (state_q == ST_EXEC) && exec_last;
    pc_upd_stb     = !rst && (state_q == ST_UPDATE);
    busy           = (state_q != ST_HALT);
  end

  // A halt request seen at any point is held until the running instruction retires.
  always_comb begin
    inst_d      = inst_load ? imem.imem_rdata : inst_q;
    err_d       = err_q || misalign;
    halt_pend_d = halt_pend_q || (halt_req && (state_q != ST_HALT));
    pc_d        = pc_q;
    if (state_q == ST_UPDATE && !misalign) pc_d = redirect ? target : pc_next_seq;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_VECTOR;
      inst_q      <= '0;
      err_q       <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      err_q       <= err_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign pc           = pc_q;
  assign inst         = inst_q;
  assign misalign_err = err_q;

`ifdef INSTRET_CNT_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst)                                       instret_q <= '0;
    else if (state_q == ST_UPDATE && !misalign)    instret_q <= instret_q + 64'd1;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - directed self-checking bench for pc_seq (default and EXEC_CYCLES=3)
module tb_pc_seq;

  localparam logic [31:0] RV = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_seq_if #(.XLEN(32)) ifa ();
  pc_seq_if #(.XLEN(32)) ifb ();

  logic [31:0] inst_a, pc_a, nxt_a, target_a;
  logic [31:0] inst_b, pc_b, nxt_b, target_b;
  logic        redirect_a, halt_a, rfw_a, upd_a, busy_a, err_a;
  logic        redirect_b, halt_b, rfw_b, upd_b, busy_b, err_b;
`ifdef INSTRET_CNT_EN
  logic [63:0] instret_a, instret_b;
`endif

  pc_seq dut_a (
    .clk(clk), .rst(rst), .imem(ifa),
    .inst(inst_a), .pc(pc_a), .pc_next_seq(nxt_a),
    .redirect(redirect_a), .target(target_a), .halt_req(halt_a),
    .rf_wen_stb(rfw_a), .pc_upd_stb(upd_a), .busy(busy_a), .misalign_err(err_a)
`ifdef INSTRET_CNT_EN
    , .instret(instret_a)
`endif
  );

  pc_seq #(.EXEC_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .imem(ifb),
    .inst(inst_b), .pc(pc_b), .pc_next_seq(nxt_b),
    .redirect(redirect_b), .target(target_b), .halt_req(halt_b),
    .rf_wen_stb(rfw_b), .pc_upd_stb(upd_b), .busy(busy_b), .misalign_err(err_b)
`ifdef INSTRET_CNT_EN
    , .instret(instret_b)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_pc;
  int          upd_cnt;

  initial begin
    rst = 1'b1;
    ifa.imem_gnt = 1'b0; ifa.imem_rvalid = 1'b0; ifa.imem_rdata = '0;
    ifb.imem_gnt = 1'b0; ifb.imem_rvalid = 1'b0; ifb.imem_rdata = '0;
    redirect_a = 1'b0; target_a = '0; halt_a = 1'b0;
    redirect_b = 1'b0; target_b = '0; halt_b = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pc", pc_a, RV);
    chk("rst_inst", inst_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_busy", busy_a, 1);
    chk("rst_upd", upd_a, 0);
    chk("rst_rfw", rfw_a, 0);
`ifdef INSTRET_CNT_EN
    chk("rst_instret", instret_a, 0);
`endif

    // Back-to-back fetches with gnt/rvalid tied high: 3-cycle period
    rst = 1'b0;
    ifa.imem_gnt = 1'b1; ifa.imem_rvalid = 1'b1; ifa.imem_rdata = 32'h1234_5678;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      exp_pc = RV + 32'(4 * (i / 3));
      chk("seq_upd", upd_a, (i % 3) == 2);
      chk("seq_req", ifa.imem_req, (i % 3) == 0);
      chk("seq_pc", pc_a, exp_pc);
      chk("seq_addr", ifa.imem_addr, exp_pc);
      if (i == 1) begin
        chk("seq_inst", inst_a, 32'h1234_5678);
        chk("seq_rfw", rfw_a, 1);
      end
    end

    // Aligned redirect
    redirect_a = 1'b1; target_a = 32'h8000_0100;
    @(negedge clk);
    chk("redir_addr", ifa.imem_addr, 32'h8000_0100);
`ifdef INSTRET_CNT_EN
    chk("redir_instret", instret_a, 3);
`endif
    redirect_a = 1'b0;
    repeat (2) @(negedge clk);
    chk("redir2_upd", upd_a, 1);
    redirect_a = 1'b1; target_a = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("wrap_pc", pc_a, 32'hFFFF_FFFC);
    chk("wrap_nxt", nxt_a, 0);
    redirect_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("wrap_pc0", pc_a, 0);

    // Misaligned redirect
    repeat (2) @(negedge clk);
    chk("mis_upd", upd_a, 1);
    redirect_a = 1'b1; target_a = 32'h8000_0102;
    @(negedge clk);
    redirect_a = 1'b0;
    chk("mis_err", err_a, 1);
    chk("mis_busy", busy_a, 0);
    chk("mis_pc", pc_a, 0);
    chk("mis_req", ifa.imem_req, 0);
    @(negedge clk);
    chk("mis_hold_busy", busy_a, 0);
    chk("mis_hold_upd", upd_a, 0);
    chk("mis_hold_err", err_a, 1);
`ifdef INSTRET_CNT_EN
    chk("mis_instret", instret_a, 5);
`endif

    // Reset while in WAIT, with a response arriving during reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ifa.imem_gnt = 1'b1; ifa.imem_rvalid = 1'b0;
    @(negedge clk);
    chk("wait_req", ifa.imem_req, 0);
    chk("wait_busy", busy_a, 1);
    rst = 1'b1; ifa.imem_rvalid = 1'b1; ifa.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wrst_pc", pc_a, RV);
    chk("wrst_inst", inst_a, 0);
    chk("wrst_upd", upd_a, 0);
    chk("wrst_rfw", rfw_a, 0);
    chk("wrst_req", ifa.imem_req, 1);
    chk("wrst_err", err_a, 0);

    // Ten instructions, then halt pulsed during EXEC of the eleventh
    rst = 1'b0; ifa.imem_gnt = 1'b1; ifa.imem_rvalid = 1'b1; ifa.imem_rdata = 32'h0000_0013;
    upd_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      upd_cnt += int'(upd_a);
    end
    @(negedge clk);
    chk("ten_upd_cnt", upd_cnt, 10);
    chk("ten_pc", pc_a, 32'h8000_0028);
`ifdef INSTRET_CNT_EN
    chk("ten_instret", instret_a, 10);
`endif
    @(negedge clk);
    halt_a = 1'b1;
    @(negedge clk);
    halt_a = 1'b0;
    chk("halt_upd", upd_a, 1);
    @(negedge clk);
    chk("halt_busy", busy_a, 0);
    chk("halt_req", ifa.imem_req, 0);
    chk("halt_pc", pc_a, 32'h8000_002C);
`ifdef INSTRET_CNT_EN
    chk("halt_instret", instret_a, 11);
`endif
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("halted_req", ifa.imem_req, 0);
      chk("halted_busy", busy_a, 0);
    end

    // EXEC_CYCLES=3, gnt after 2 idle cycles, rvalid one cycle later, stray rvalid in EXEC
    rst = 1'b1; ifa.imem_gnt = 1'b0; ifa.imem_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 17; j++) begin
      if (j > 0) @(negedge clk);
      chk("b_rfw", rfw_b, (j % 8) == 6);
      chk("b_upd", upd_b, (j % 8) == 7);
      chk("b_req", ifb.imem_req, (j % 8) <= 2);
      chk("b_pc", pc_b, RV + 32'(4 * (j / 8)));
      if ((j % 8) == 6) chk("b_inst", inst_b, 32'hCAFE_0000 + 32'(j / 8));
      ifb.imem_gnt    = ((j % 8) == 2);
      ifb.imem_rvalid = ((j % 8) == 3) || ((j % 8) == 5);
      ifb.imem_rdata  = ((j % 8) == 3) ? 32'hCAFE_0000 + 32'(j / 8) : 32'hBAD0_BAD0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h8000_0000, PC value after reset.
REQ-003 SHALL have parameter EXEC_CYCLES, default 1, execute-phase length (legal range 1..4).
REQ-004 SHALL have parameter PC_STEP, default 4, sequential PC increment.
REQ-005 SHALL have ports, one per line:
  clk  in  1  clock, rising edge
  rst  in  1  reset, synchronous, active-high
  imem_req  out  1  fetch request
  imem_addr  out  XLEN  fetch address, always equal to pc
  imem_gnt  in  1  request accepted
  imem_rvalid  in  1  fetch data valid
  imem_rdata  in  XLEN  fetch data
  inst  out  XLEN  latched instruction
  pc  out  XLEN  current PC
  pc_next_seq  out  XLEN  pc + PC_STEP, combinational
  redirect  in  1  take target instead of pc_next_seq
  target  in  XLEN  redirect target
  halt_req  in  1  stop after current instruction
  rf_wen_stb  out  1  one-cycle register-file write strobe
  pc_upd_stb  out  1  one-cycle PC update strobe
  busy  out  1  high in every state except HALT
  misalign_err  out  1  sticky misaligned-target flag
  instret  out  64  retired-instruction count (INSTRET_CNT_EN only)

Function
REQ-006 SHALL implement FSM states FETCH, WAIT, EXEC, UPDATE, HALT.
REQ-007 FETCH: imem_req=1; on imem_gnt=1 go WAIT, or go EXEC directly if imem_rvalid=1 in the same cycle.
REQ-008 WAIT: imem_req=0; on imem_rvalid=1 latch imem_rdata into inst and go EXEC; otherwise stay WAIT.
REQ-009 imem_rvalid SHALL be ignored in every state other than FETCH (with gnt) and WAIT.
REQ-010 EXEC: SHALL stay exactly EXEC_CYCLES cycles, counted by an internal counter cleared on entry; rf_wen_stb=1 on the last EXEC cycle only.
REQ-011 UPDATE: pc_upd_stb=1 for one cycle; pc <= target when redirect=1, else pc_next_seq; redirect and target are sampled in this cycle only.
REQ-012 From UPDATE: go HALT if halt_req=1 or a misalign error occurs in that cycle, else go FETCH.
REQ-013 Minimum instruction period SHALL be EXEC_CYCLES+2 cycles (3 at default).
REQ-014 Misaligned redirect: redirect=1 in UPDATE with target[1:0]!=0 SHALL leave pc unchanged, set misalign_err, and go HALT.
REQ-015 HALT: all strobes and imem_req 0, busy=0; SHALL exit only by reset.
REQ-016 pc_next_seq SHALL wrap modulo 2^XLEN.
REQ-017 inst SHALL hold its value from latch until the next latch.

Reset
REQ-018 On rst=1 at a clock edge, in any state including mid-fetch: state=FETCH, pc=RESET_VECTOR, inst=0, EXEC counter=0, misalign_err=0, instret=0.
REQ-019 During reset all strobes SHALL be 0; imem_req SHALL be 1 in the first cycle after reset.
REQ-020 An outstanding imem response arriving after reset SHALL be discarded unless its state is FETCH or WAIT (owner's responsibility to drain).

Configuration
REQ-021 Macro INSTRET_CNT_EN defined: instret increments by 1 in every UPDATE cycle that does not raise misalign_err, wrapping at 2^64.
REQ-022 Macro INSTRET_CNT_EN undefined: instret port and counter are absent.

Structure
REQ-023 State encoding, RESET_VECTOR default and PC_STEP default SHALL live in the shared defines package.
REQ-024 The EXEC-phase counter SHALL be a sub-module named phase_cnt (parameter EXEC_CYCLES, outputs last-cycle flag).

Verification
REQ-025 Reset, then gnt and rvalid held 1, redirect=0 -> pc goes 0x8000_0000, 0x8000_0004, 0x8000_0008, one pc_upd_stb every 3 cycles.
REQ-026 EXEC_CYCLES=3, gnt delayed 2 cycles, rvalid 1 cycle after gnt -> period 8 cycles, rf_wen_stb exactly 1 cycle, 3 cycles after inst latch.
REQ-027 redirect=1, target=0x8000_0100 in UPDATE -> next imem_addr=0x8000_0100; target=0x8000_0102 -> misalign_err=1, pc unchanged, busy=0.
REQ-028 halt_req pulsed during EXEC -> current instruction completes, no further imem_req, busy=0 until rst.
REQ-029 rst asserted in WAIT -> next cycle state FETCH, pc=RESET_VECTOR, no stale strobe.
REQ-030 INSTRET_CNT_EN defined, 10 instructions retired -> instret=10; pc=0xFFFF_FFFC sequential -> pc wraps to 0.
